// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode, ALU-op and sequencer-state definitions for the
//               bus-based CPU control path.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes (instr[31:27])
    localparam logic [4:0] C_OP_LD   = 5'b00000;
    localparam logic [4:0] C_OP_LDI  = 5'b00001;
    localparam logic [4:0] C_OP_ST   = 5'b00010;
    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_ADDI = 5'b01100;
    localparam logic [4:0] C_OP_ANDI = 5'b01101;
    localparam logic [4:0] C_OP_ORI  = 5'b01110;
    localparam logic [4:0] C_OP_BR   = 5'b10010;
    localparam logic [4:0] C_OP_JR   = 5'b10100;
    localparam logic [4:0] C_OP_NOP  = 5'b11010;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    // ALU operation codes
    localparam logic [3:0] C_ALU_ADD = 4'd0;
    localparam logic [3:0] C_ALU_SUB = 4'd1;
    localparam logic [3:0] C_ALU_AND = 4'd2;
    localparam logic [3:0] C_ALU_OR  = 4'd3;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    // Instruction families sharing an execute sequence
    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_BR, CL_JR, CL_NOP, CL_HALT
    } op_class_t;

    // Full strobe vector driven by the sequencer
    typedef struct packed {
        logic       run;
        logic [3:0] alu_op;
        logic       pc_out, mar_in, inc_pc, pc_in, mdr_in, mdr_out, ir_in;
        logic       y_in, z_in, zlo_out, c_out, con_in, mem_read, mem_write;
        logic       gra, grb, grc, r_in, r_out, ba_out;
    } ctrl_t;

    // Undefined opcodes fall into the nop family
    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR: classify = CL_RTYPE;
            C_OP_ADDI, C_OP_ANDI, C_OP_ORI:        classify = CL_IMM;
            C_OP_LDI:                              classify = CL_LDI;
            C_OP_LD:                               classify = CL_LD;
            C_OP_ST:                               classify = CL_ST;
            C_OP_BR:                               classify = CL_BR;
            C_OP_JR:                               classify = CL_JR;
            C_OP_HALT:                             classify = CL_HALT;
            default:                               classify = CL_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_sel(input logic [4:0] op);
        case (op)
            C_OP_SUB:            alu_sel = C_ALU_SUB;
            C_OP_AND, C_OP_ANDI: alu_sel = C_ALU_AND;
            C_OP_OR,  C_OP_ORI:  alu_sel = C_ALU_OR;
            default:             alu_sel = C_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Moore output decode: current T-state + opcode -> strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_t         i_state,
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_con,
    output ctrl_t          o_ctrl
);

    op_class_t  w_class;
    logic [3:0] w_alu;

    assign w_class = classify(5'(i_opcode));
    assign w_alu   = alu_sel(5'(i_opcode));

    // Strobe decode; anything not named for a state stays 0, ALU defaults to ADD
    always_comb begin
        o_ctrl        = '0;
        o_ctrl.alu_op = C_ALU_ADD;
        o_ctrl.run    = (i_state != RESET) && (i_state != HALT);
        case (i_state)
            T0: begin
                o_ctrl.pc_out = 1'b1; o_ctrl.mar_in = 1'b1;
                o_ctrl.inc_pc = 1'b1; o_ctrl.z_in   = 1'b1;
            end
            T1: begin
                o_ctrl.zlo_out  = 1'b1; o_ctrl.pc_in  = 1'b1;
                o_ctrl.mem_read = 1'b1; o_ctrl.mdr_in = 1'b1;
            end
            T2: begin
                o_ctrl.mdr_out = 1'b1; o_ctrl.ir_in = 1'b1;
            end
            T3: begin
                case (w_class)
                    CL_RTYPE, CL_IMM: begin
                        o_ctrl.grb = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        o_ctrl.grb = 1'b1; o_ctrl.ba_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    CL_BR: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.con_in = 1'b1;
                    end
                    CL_JR: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (w_class)
                    CL_RTYPE: begin
                        o_ctrl.grc = 1'b1; o_ctrl.r_out = 1'b1;
                        o_ctrl.z_in = 1'b1; o_ctrl.alu_op = w_alu;
                    end
                    CL_IMM: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.z_in = 1'b1; o_ctrl.alu_op = w_alu;
                    end
                    CL_LDI, CL_LD, CL_ST: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.z_in = 1'b1;
                    end
                    CL_BR: begin
                        o_ctrl.pc_out = 1'b1; o_ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (w_class)
                    CL_RTYPE, CL_IMM, CL_LDI: begin
                        o_ctrl.zlo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        o_ctrl.zlo_out = 1'b1; o_ctrl.mar_in = 1'b1;
                    end
                    CL_BR: begin
                        o_ctrl.c_out = 1'b1; o_ctrl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (w_class)
                    CL_LD: begin
                        o_ctrl.mem_read = 1'b1; o_ctrl.mdr_in = 1'b1;
                    end
                    CL_ST: begin
                        o_ctrl.gra = 1'b1; o_ctrl.r_out = 1'b1; o_ctrl.mdr_in = 1'b1;
                    end
                    CL_BR: begin
                        o_ctrl.zlo_out = 1'b1; o_ctrl.pc_in = i_con;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (w_class)
                    CL_LD: begin
                        o_ctrl.mdr_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.r_in = 1'b1;
                    end
                    CL_ST:   o_ctrl.mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq
// Description : Hardwired multi-cycle control sequencer (fetch/decode/execute
//               T-states, memory ready handshake, halt).
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clk,
    input  logic            clear_n,
    input  logic [31:0]     instr,
    input  logic            con,
    input  logic            mem_done,
    output logic            pc_out,
    output logic            mar_in,
    output logic            inc_pc,
    output logic            pc_in,
    output logic            mdr_in,
    output logic            mdr_out,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            zlo_out,
    output logic            c_out,
    output logic            con_in,
    output logic            mem_read,
    output logic            mem_write,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            r_in,
    output logic            r_out,
    output logic            ba_out,
    output logic [ALUW-1:0] alu_op,
    output logic            run
);

    state_t         r_state;
    state_t         w_next;
    op_class_t      w_class;
    logic [OPW-1:0] w_opcode;
    ctrl_t          w_ctrl;
    logic           w_unused_instr;

    // The IR holds the opcode steady for the whole execute phase
    assign w_opcode       = instr[31 -: OPW];
    assign w_class        = classify(5'(w_opcode));
    assign w_unused_instr = ^instr[31-OPW:0];

    // State register; clear_n drops the sequencer into RESET immediately
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) r_state <= RESET;
        else          r_state <= w_next;
    end

    // Next-state: fixed step order per instruction family, memory waits on mem_done
    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET: w_next = T0;
            T0:    w_next = T1;
            T1:    w_next = mem_done ? T2 : T1;
            T2:    w_next = T3;
            T3: begin
                case (w_class)
                    CL_HALT:       w_next = HALT;
                    CL_JR, CL_NOP: w_next = T0;
                    default:       w_next = T4;
                endcase
            end
            T4:    w_next = T5;
            T5:    w_next = (w_class inside {CL_LD, CL_ST, CL_BR}) ? T6 : T0;
            T6: begin
                case (w_class)
                    CL_LD:   w_next = mem_done ? T7 : T6;
                    CL_ST:   w_next = T7;
                    default: w_next = T0;
                endcase
            end
            T7:    w_next = (w_class == CL_ST && !mem_done) ? T7 : T0;
            HALT:  w_next = HALT;
            default: w_next = RESET;
        endcase
    end

    ctrl_decode #(.OPW(OPW)) u_decode (
        .i_state  (r_state),
        .i_opcode (w_opcode),
        .i_con    (con),
        .o_ctrl   (w_ctrl)
    );

    assign pc_out    = w_ctrl.pc_out;
    assign mar_in    = w_ctrl.mar_in;
    assign inc_pc    = w_ctrl.inc_pc;
    assign pc_in     = w_ctrl.pc_in;
    assign mdr_in    = w_ctrl.mdr_in;
    assign mdr_out   = w_ctrl.mdr_out;
    assign ir_in     = w_ctrl.ir_in;
    assign y_in      = w_ctrl.y_in;
    assign z_in      = w_ctrl.z_in;
    assign zlo_out   = w_ctrl.zlo_out;
    assign c_out     = w_ctrl.c_out;
    assign con_in    = w_ctrl.con_in;
    assign mem_read  = w_ctrl.mem_read;
    assign mem_write = w_ctrl.mem_write;
    assign gra       = w_ctrl.gra;
    assign grb       = w_ctrl.grb;
    assign grc       = w_ctrl.grc;
    assign r_in      = w_ctrl.r_in;
    assign r_out     = w_ctrl.r_out;
    assign ba_out    = w_ctrl.ba_out;
    assign alu_op    = ALUW'(w_ctrl.alu_op);
    assign run       = w_ctrl.run;

endmodule
`default_nettype wire
